seq_step_ctrl: RTL and testbench



---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_debounce.sv | 40 ++++
 rtl/seq_step_ctrl.sv | 96 +++++++++
 tb/tb_seq_step_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default timing constants for the step scheduler
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_STEP  = 2'd2,
    ST_CHECK = 2'd3
  } step_state_t;

  localparam int DIV_MAX_DEF    = 20000000;
  localparam int DEB_CYCLES_DEF = 200000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_debounce.sv
// rtl/seq_debounce.sv - 2-flop synchronizer followed by a consecutive-cycle debounce filter
module seq_debounce
  import seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEB_CYCLES);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // Enough consecutive disagreeing samples: accept the new level.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_step_ctrl.sv
// rtl/seq_step_ctrl.sv - step-enable scheduler: auto divider or debounced button, sampled input, hit counter
module seq_step_ctrl
  import seq_pkg::*;
#(
  parameter int DIV_MAX    = DIV_MAX_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_raw,
  input  logic             step_btn,
  input  logic             auto_mode,
  input  logic             det_hit,
  input  logic             cnt_clr,
  output logic             step_en,
  output logic             x_smp,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             tick_led
);

  localparam int DW = cnt_width(DIV_MAX);
  localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

  step_state_t   state;
  step_state_t   state_next;
  logic          x_deb;
  logic          btn_deb;
  logic          btn_prev;
  logic          auto_meta;
  logic          auto_sync;
  logic [DW-1:0] div_cnt;
  logic          auto_tick;
  logic          btn_rise;
  logic          req;

  seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_x (
    .clk   (clk),
    .rst   (rst),
    .raw   (x_raw),
    .level (x_deb)
  );

  seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (step_btn),
    .level (btn_deb)
  );

  assign auto_tick = auto_sync && (div_cnt == DW'(DIV_MAX - 1));
  assign btn_rise  = btn_deb && !btn_prev && !auto_sync;
  assign req       = auto_tick || btn_rise;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_STEP;
      ST_STEP:  state_next = ST_CHECK;
      ST_CHECK: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
      div_cnt   <= '0;
      btn_prev  <= 1'b0;
      state     <= ST_IDLE;
      step_en   <= 1'b0;
      x_smp     <= 1'b0;
      tick_led  <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      auto_meta <= auto_mode;
      auto_sync <= auto_meta;
      if (!auto_sync || auto_tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + 1'b1;
      btn_prev <= btn_deb;
      state    <= state_next;
      // Registered so step_en is high exactly while the FSM sits in STEP.
      step_en  <= (state_next == ST_STEP);
      if (state == ST_LATCH) x_smp <= x_deb;
      if (state == ST_STEP)  tick_led <= ~tick_led;
      if (cnt_clr) begin
        hit_cnt <= '0;
      end else if (state == ST_CHECK && det_hit && hit_cnt != HIT_MAX) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// tb/tb_seq_step_ctrl.sv - directed plus randomized checks of seq_step_ctrl against a rule-level reference model
module tb_seq_step_ctrl;

  localparam int DIV = 8;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst, x_raw, step_btn, auto_mode, det_hit, cnt_clr;
  logic step_en, x_smp, tick_led;
  logic [7:0] hit_cnt;
  logic step_en_s, x_smp_s, tick_led_s;
  logic [1:0] hit_cnt_s;

  always #5 clk = ~clk;

  seq_step_ctrl #(.DIV_MAX(DIV), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x_raw(x_raw), .step_btn(step_btn), .auto_mode(auto_mode),
    .det_hit(det_hit), .cnt_clr(cnt_clr), .step_en(step_en), .x_smp(x_smp),
    .hit_cnt(hit_cnt), .tick_led(tick_led)
  );

  seq_step_ctrl #(.DIV_MAX(DIV), .DEB_CYCLES(DEB), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .x_raw(x_raw), .step_btn(step_btn), .auto_mode(auto_mode),
    .det_hit(det_hit), .cnt_clr(cnt_clr), .step_en(step_en_s), .x_smp(x_smp_s),
    .hit_cnt(hit_cnt_s), .tick_led(tick_led_s)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_steps  = 0;

  // Reference model: delay lines, run-length debounce, run-length divider, sequence phase.
  logic m_x_s0, m_x_s1, m_b_s0, m_b_s1, m_a_s0, m_a_s1;
  logic m_x_deb, m_b_deb, m_b_deb_q;
  int   m_x_run, m_b_run, m_auto_run;
  int   m_phase;
  logic m_x_smp, m_led;
  int   m_hits8, m_hits2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic deb_update(input logic s, input logic lvl_in, input int run_in,
                            output logic lvl, output int run);
    lvl = lvl_in;
    run = run_in;
    if (s == lvl_in) begin
      run = 0;
    end else begin
      run = run_in + 1;
      if (run == DEB) begin
        lvl = ~lvl_in;
        run = 0;
      end
    end
  endtask

  task automatic model_reset();
    {m_x_s0, m_x_s1, m_b_s0, m_b_s1, m_a_s0, m_a_s1} = '0;
    {m_x_deb, m_b_deb, m_b_deb_q, m_x_smp, m_led} = '0;
    m_x_run = 0; m_b_run = 0; m_auto_run = 0; m_phase = 0;
    m_hits8 = 0; m_hits2 = 0;
  endtask

  task automatic model_edge();
    logic tick, rise, req, nl;
    int   nr;
    if (rst) begin
      model_reset();
      return;
    end
    tick = m_a_s1 && ((m_auto_run % DIV) == DIV - 1);
    rise = m_b_deb && !m_b_deb_q && !m_a_s1;
    req  = tick || rise;
    if (m_phase == 1) m_x_smp = m_x_deb;
    if (m_phase == 2) m_led = ~m_led;
    if (m_phase == 3 && det_hit) begin
      if (m_hits8 < 255) m_hits8++;
      if (m_hits2 < 3)   m_hits2++;
    end
    if (cnt_clr) begin
      m_hits8 = 0;
      m_hits2 = 0;
    end
    m_phase    = (m_phase == 0) ? (req ? 1 : 0) : (m_phase + 1) % 4;
    m_b_deb_q  = m_b_deb;
    m_auto_run = m_a_s1 ? m_auto_run + 1 : 0;
    deb_update(m_x_s1, m_x_deb, m_x_run, nl, nr); m_x_deb = nl; m_x_run = nr;
    deb_update(m_b_s1, m_b_deb, m_b_run, nl, nr); m_b_deb = nl; m_b_run = nr;
    m_x_s1 = m_x_s0; m_x_s0 = x_raw;
    m_b_s1 = m_b_s0; m_b_s0 = step_btn;
    m_a_s1 = m_a_s0; m_a_s0 = auto_mode;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    if (step_en) n_steps++;
    check("step_en",   32'(step_en),   32'(m_phase == 2));
    check("x_smp",     32'(x_smp),     32'(m_x_smp));
    check("tick_led",  32'(tick_led),  32'(m_led));
    check("hit_cnt",   32'(hit_cnt),   32'(m_hits8));
    check("hit_cnt_2", 32'(hit_cnt_s), 32'(m_hits2));
    check("step_en_2", 32'(step_en_s), 32'(m_phase == 2));
  endtask

  task automatic wait_steps(input int n, input string tag);
    int target = n_steps + n;
    int budget = 0;
    while (n_steps < target && budget < 300) begin
      cycle();
      budget++;
    end
    check(tag, 32'(n_steps >= target), 32'd1);
  endtask

  initial begin
    int s0, first;
    model_reset();
    rst = 1'b1; x_raw = 1'b0; step_btn = 1'b0; auto_mode = 1'b0; det_hit = 1'b0; cnt_clr = 1'b0;
    repeat (3) cycle();
    check("rst_step_en",  32'(step_en),  32'd0);
    check("rst_x_smp",    32'(x_smp),    32'd0);
    check("rst_hit_cnt",  32'(hit_cnt),  32'd0);
    check("rst_tick_led", 32'(tick_led), 32'd0);
    rst = 1'b0;

    // Auto stepping, then a mid-run change of the serial input.
    auto_mode = 1'b1;
    repeat (20) cycle();
    x_raw = 1'b1;
    s0 = n_steps;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (step_en && first < 0) first = i;
      if (first > 0 && i == first + DIV) check("auto_period", 32'(step_en), 32'd1);
    end
    check("auto_step_count", 32'(n_steps - s0), 32'd5);
    check("x_smp_follows", 32'(x_smp), 32'd1);

    // Manual mode: glitch ignored, clean press gives one step 2+DEB+2 cycles after onset.
    auto_mode = 1'b0;
    repeat (12) cycle();
    s0 = n_steps;
    step_btn = 1'b1;
    repeat (2) cycle();
    step_btn = 1'b0;
    repeat (12) cycle();
    check("glitch_no_step", 32'(n_steps - s0), 32'd0);
    s0 = n_steps;
    first = -1;
    step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (step_en && first < 0) first = i;
    end
    step_btn = 1'b0;
    repeat (15) cycle();
    check("press_latency", 32'(first), 32'(2 + DEB + 2));
    check("press_one_step", 32'(n_steps - s0), 32'd1);

    // Hit counting and saturation.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    det_hit = 1'b1;
    auto_mode = 1'b1;
    wait_steps(3, "wait_three_steps");
    repeat (2) cycle();
    check("hits_three",     32'(hit_cnt),   32'd3);
    check("hits_three_sat", 32'(hit_cnt_s), 32'd3);
    wait_steps(2, "wait_two_more");
    repeat (2) cycle();
    check("hits_five",      32'(hit_cnt),   32'd5);
    check("hits_saturated", 32'(hit_cnt_s), 32'd3);

    // Clear coinciding with an increment on the CHECK cycle.
    wait_steps(1, "wait_clr_step");
    cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("clr_wins",     32'(hit_cnt),   32'd0);
    check("clr_wins_sat", 32'(hit_cnt_s), 32'd0);

    // Reset while in STEP.
    wait_steps(1, "wait_rst_step");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_step_en", 32'(step_en), 32'd0);
    check("rst_mid_hit_cnt", 32'(hit_cnt), 32'd0);
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (step_en && first < 0) first = i;
    end
    check("rst_restart_seen",     32'(first > 0),    32'd1);
    check("rst_restart_not_early", 32'(first >= DIV), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 700; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 9) == 0)  x_raw = ~x_raw;
      if ($urandom_range(0, 7) == 0)  step_btn = ~step_btn;
      if ($urandom_range(0, 79) == 0) auto_mode = ~auto_mode;
      det_hit = $urandom_range(0, 1) == 1;
      cnt_clr = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
